// File: rtl/cursor_ctrl.sv
// cursor_ctrl: turns debounced direction, colour and width buttons into a
// clamped cursor position, a colour index and a stroke-width index.
// Direction buttons move the cursor on press. Holding a direction repeats
// the move after a delay, at a fixed period, and the step keeps doubling
// up to a ceiling. Colour and width step up or down on button press and
// wrap around at both ends.
module cursor_ctrl #(
    parameter int H_PIX         = 640,
    parameter int V_PIX         = 360,
    parameter int STEP          = 5,
    parameter int STEP_MAX      = 40,
    parameter int ACCEL_REPEATS = 8,
    parameter int REPEAT_DELAY  = 2_000_000,
    parameter int REPEAT_PERIOD = 500_000,
    parameter int NUM_COLORS    = 16,
    parameter int NUM_WIDTHS    = 8,
    localparam int XW = $clog2(H_PIX),
    localparam int YW = $clog2(V_PIX),
    localparam int CW = $clog2(NUM_COLORS),
    localparam int SW = $clog2(NUM_WIDTHS)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [3:0]    pos_con_in,
    input  logic [1:0]    col_con_in,
    input  logic [1:0]    sw_con_in,
    output logic [XW-1:0] cursor_loc_x,
    output logic [YW-1:0] cursor_loc_y,
    output logic [CW-1:0] cursor_color,
    output logic [SW-1:0] stroke_width,
    output logic          moved_out,
    output logic [7:0]    cur_step_out
);

    // One counter serves both the initial delay and the repeat period, so
    // it is sized for the larger of the two.
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(ACCEL_REPEATS + 1);

    localparam logic [CNTW-1:0] DELAY_LAST  = CNTW'(REPEAT_DELAY - 1);
    localparam logic [CNTW-1:0] PERIOD_LAST = CNTW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0]   ACCEL_LAST  = RW'(ACCEL_REPEATS - 1);
    localparam logic [7:0]      STEP_INIT   = 8'(STEP);
    localparam logic [8:0]      STEP_CEIL   = 9'(STEP_MAX);

    // Move sums are formed one bit wider than either operand so that an
    // overshoot past the far edge is visible before clamping.
    localparam int XAW = ((XW > 8) ? XW : 8) + 1;
    localparam int YAW = ((YW > 8) ? YW : 8) + 1;
    localparam logic [XAW-1:0] X_LAST = XAW'(H_PIX - 1);
    localparam logic [YAW-1:0] Y_LAST = YAW'(V_PIX - 1);

    localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLORS - 1);
    localparam logic [SW-1:0] SW_LAST  = SW'(NUM_WIDTHS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    // Hold state machine registers
    state_t          r_state;
    logic [3:0]      r_pat;
    logic [CNTW-1:0] r_cnt;
    logic [RW-1:0]   r_rep;
    logic [7:0]      r_step;
    logic            r_pos_blk;

    // Output and edge-history registers
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_moved;
    logic [CW-1:0]   r_col;
    logic [SW-1:0]   r_sw;
    logic [1:0]      r_col_hist;
    logic [1:0]      r_col_mask;
    logic [1:0]      r_sw_hist;
    logic [1:0]      r_sw_mask;

    logic            w_pat_nz;
    logic            w_new_press;
    logic            w_move;
    logic [7:0]      w_move_step;
    logic [8:0]      w_step_x2;
    logic [7:0]      w_step_dbl;

    logic            w_up;
    logic            w_down;
    logic            w_right;
    logic            w_left;

    logic [XAW-1:0]  w_x_ext;
    logic [XAW-1:0]  w_x_stp;
    logic [XAW-1:0]  w_x_sum;
    logic [XAW-1:0]  w_x_dif;
    logic [YAW-1:0]  w_y_ext;
    logic [YAW-1:0]  w_y_stp;
    logic [YAW-1:0]  w_y_sum;
    logic [YAW-1:0]  w_y_dif;
    logic [XW-1:0]   w_x_next;
    logic [YW-1:0]   w_y_next;

    logic [1:0]      w_col_rise;
    logic [1:0]      w_sw_rise;
    logic [CW-1:0]   w_col_next;
    logic [SW-1:0]   w_sw_next;

    // A new nonzero pattern always restarts the hold. r_pat is cleared in
    // IDLE, so the first press counts as a new pattern too. r_pos_blk stops
    // a direction that was held through reset from moving the cursor until
    // every direction button has been released.
    assign w_pat_nz    = |pos_con_in;
    assign w_new_press = w_pat_nz && (pos_con_in != r_pat) && !r_pos_blk;

    assign w_step_x2  = {r_step, 1'b0};
    assign w_step_dbl = (w_step_x2 > STEP_CEIL) ? STEP_CEIL[7:0] : w_step_x2[7:0];

    // Decide whether a move happens in this cycle and what step it uses
    always_comb begin
        w_move      = 1'b0;
        w_move_step = r_step;
        if (w_new_press) begin
            w_move      = 1'b1;
            w_move_step = STEP_INIT;
        end else if (w_pat_nz && (r_state == S_DELAY) && (r_cnt == DELAY_LAST)) begin
            w_move = 1'b1;
        end else if (w_pat_nz && (r_state == S_REPEAT) && (r_cnt == PERIOD_LAST)) begin
            w_move = 1'b1;
        end
    end

    // Hold FSM: press, wait for the delay, repeat at the period, and double
    // the step after each ACCEL_REPEATS repeat moves
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_cnt     <= '0;
            r_rep     <= '0;
            r_step    <= STEP_INIT;
            r_pos_blk <= w_pat_nz;
        end else if (!w_pat_nz) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_cnt     <= '0;
            r_rep     <= '0;
            r_step    <= STEP_INIT;
            r_pos_blk <= 1'b0;
        end else if (w_new_press) begin
            r_state <= S_DELAY;
            r_pat   <= pos_con_in;
            r_cnt   <= '0;
            r_rep   <= '0;
            r_step  <= STEP_INIT;
        end else begin
            case (r_state)
                S_DELAY: begin
                    if (r_cnt == DELAY_LAST) begin
                        r_state <= S_REPEAT;
                        r_cnt   <= '0;
                        if (r_rep == ACCEL_LAST) begin
                            r_rep  <= '0;
                            r_step <= w_step_dbl;
                        end else begin
                            r_rep <= r_rep + RW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_REPEAT: begin
                    if (r_cnt == PERIOD_LAST) begin
                        r_cnt <= '0;
                        if (r_rep == ACCEL_LAST) begin
                            r_rep  <= '0;
                            r_step <= w_step_dbl;
                        end else begin
                            r_rep <= r_rep + RW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                default: begin
                    // IDLE with the blocked pattern still held: wait for release
                end
            endcase
        end
    end

    // Opposing buttons on the same axis cancel out
    assign w_up    = pos_con_in[0] & ~pos_con_in[1];
    assign w_down  = pos_con_in[1] & ~pos_con_in[0];
    assign w_right = pos_con_in[2] & ~pos_con_in[3];
    assign w_left  = pos_con_in[3] & ~pos_con_in[2];

    assign w_x_ext = XAW'(r_x);
    assign w_x_stp = XAW'(w_move_step);
    assign w_x_sum = w_x_ext + w_x_stp;
    assign w_x_dif = w_x_ext - w_x_stp;
    assign w_y_ext = YAW'(r_y);
    assign w_y_stp = YAW'(w_move_step);
    assign w_y_sum = w_y_ext + w_y_stp;
    assign w_y_dif = w_y_ext - w_y_stp;

    // Next position, clamped to the visible area on both axes
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_move && w_right) begin
            w_x_next = (w_x_sum > X_LAST) ? X_LAST[XW-1:0] : w_x_sum[XW-1:0];
        end else if (w_move && w_left) begin
            w_x_next = (w_x_ext <= w_x_stp) ? '0 : w_x_dif[XW-1:0];
        end
        if (w_move && w_down) begin
            w_y_next = (w_y_sum > Y_LAST) ? Y_LAST[YW-1:0] : w_y_sum[YW-1:0];
        end else if (w_move && w_up) begin
            w_y_next = (w_y_ext <= w_y_stp) ? '0 : w_y_dif[YW-1:0];
        end
    end

    // Position registers. moved_out reports only real changes, so a move
    // that is clamped to the same place does not pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_x     <= '0;
            r_y     <= '0;
            r_moved <= 1'b0;
        end else begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_moved <= (w_x_next != r_x) || (w_y_next != r_y);
        end
    end

    // A masked bit is one that was held through reset. It never produces
    // an edge until it has been released once.
    assign w_col_rise = col_con_in & ~r_col_hist & ~r_col_mask;
    assign w_sw_rise  = sw_con_in & ~r_sw_hist & ~r_sw_mask;

    // Colour and width step by one on a single press and wrap at both ends.
    // Simultaneous up and down presses cancel.
    always_comb begin
        w_col_next = r_col;
        w_sw_next  = r_sw;
        if (w_col_rise == 2'b01) begin
            w_col_next = (r_col == COL_LAST) ? '0 : r_col + CW'(1);
        end else if (w_col_rise == 2'b10) begin
            w_col_next = (r_col == '0) ? COL_LAST : r_col - CW'(1);
        end
        if (w_sw_rise == 2'b01) begin
            w_sw_next = (r_sw == SW_LAST) ? '0 : r_sw + SW'(1);
        end else if (w_sw_rise == 2'b10) begin
            w_sw_next = (r_sw == '0) ? SW_LAST : r_sw - SW'(1);
        end
    end

    // Colour and width registers with their edge history
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_col      <= '0;
            r_sw       <= '0;
            r_col_hist <= '0;
            r_sw_hist  <= '0;
            r_col_mask <= col_con_in;
            r_sw_mask  <= sw_con_in;
        end else begin
            r_col      <= w_col_next;
            r_sw       <= w_sw_next;
            r_col_hist <= col_con_in;
            r_sw_hist  <= sw_con_in;
            r_col_mask <= r_col_mask & col_con_in;
            r_sw_mask  <= r_sw_mask & sw_con_in;
        end
    end

    assign cursor_loc_x = r_x;
    assign cursor_loc_y = r_y;
    assign cursor_color = r_col;
    assign stroke_width = r_sw;
    assign moved_out    = r_moved;
    assign cur_step_out = r_step;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl. Fast repeat timing is used so that holds fit in a
// short run. A behavioural model follows every cycle, and directed
// sequences pin literal values.
module tb_cursor_ctrl;

    localparam int H  = 640;
    localparam int V  = 360;
    localparam int ST = 5;
    localparam int SM = 20;
    localparam int AR = 2;
    localparam int D  = 10;
    localparam int P  = 4;
    localparam int NC = 16;
    localparam int NW = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] pos;
    logic [1:0] col;
    logic [1:0] sw;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] color;
    logic [2:0] width;
    logic       moved;
    logic [7:0] step;

    int n_tests = 0;
    int n_fail  = 0;

    cursor_ctrl #(
        .H_PIX(H), .V_PIX(V), .STEP(ST), .STEP_MAX(SM), .ACCEL_REPEATS(AR),
        .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .NUM_COLORS(NC), .NUM_WIDTHS(NW)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .pos_con_in(pos),
        .col_con_in(col),
        .sw_con_in(sw),
        .cursor_loc_x(x),
        .cursor_loc_y(y),
        .cursor_color(color),
        .stroke_width(width),
        .moved_out(moved),
        .cur_step_out(step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a hold is described by its age in cycles and by
    // the number of repeat moves made so far.
    int         m_x, m_y, m_col, m_sw, m_step;
    bit         m_moved;
    int         m_pat, m_age, m_nrep;
    bit         m_blk;
    bit         m_valid = 1'b0;
    logic [1:0] m_chist, m_cmask, m_shist, m_smask;

    function automatic int step_after(input int nrep);
        int e, s;
        e = nrep / AR;
        if (e > 16) e = 16;
        s = ST << e;
        return (s > SM) ? SM : s;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    always @(posedge clk) begin : model
        int         st, nx, ny, dx, dy;
        bit         mv;
        logic [1:0] cr, sr;
        if (!rst_n) begin
            m_x = 0; m_y = 0; m_col = 0; m_sw = 0; m_step = ST; m_moved = 1'b0;
            m_pat = 0; m_age = 0; m_nrep = 0;
            m_blk = (pos != 4'd0);
            m_chist = 2'b00; m_cmask = col;
            m_shist = 2'b00; m_smask = sw;
            m_valid = 1'b1;
        end else if (m_valid) begin
            mv = 1'b0;
            st = m_step;
            if (pos == 4'd0) begin
                m_blk = 1'b0; m_pat = 0; m_step = ST;
            end else if (!m_blk && int'(pos) != m_pat) begin
                mv = 1'b1; st = ST; m_pat = int'(pos); m_age = 0; m_nrep = 0; m_step = ST;
            end else if (!m_blk) begin
                m_age++;
                if (m_age == D || (m_age > D && (m_age - D) % P == 0)) begin
                    mv = 1'b1;
                    st = m_step;
                    m_nrep++;
                    m_step = step_after(m_nrep);
                end
            end
            nx = m_x; ny = m_y;
            if (mv) begin
                dx = (pos[2] && !pos[3]) ? st : ((pos[3] && !pos[2]) ? -st : 0);
                dy = (pos[1] && !pos[0]) ? st : ((pos[0] && !pos[1]) ? -st : 0);
                nx = clampi(m_x + dx, H - 1);
                ny = clampi(m_y + dy, V - 1);
            end
            m_moved = (nx != m_x) || (ny != m_y);
            m_x = nx; m_y = ny;

            cr = col & ~m_chist & ~m_cmask;
            m_chist = col; m_cmask = m_cmask & col;
            if (cr == 2'b01) m_col = (m_col + 1) % NC;
            else if (cr == 2'b10) m_col = (m_col + NC - 1) % NC;

            sr = sw & ~m_shist & ~m_smask;
            m_shist = sw; m_smask = m_smask & sw;
            if (sr == 2'b01) m_sw = (m_sw + 1) % NW;
            else if (sr == 2'b10) m_sw = (m_sw + NW - 1) % NW;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            n_tests++;
            if (int'(x) != m_x || int'(y) != m_y || int'(color) != m_col ||
                int'(width) != m_sw || moved != m_moved || int'(step) != m_step) begin
                n_fail++;
                $display("FAIL model t=%0t got x=%0d y=%0d c=%0d w=%0d mv=%0d st=%0d want x=%0d y=%0d c=%0d w=%0d mv=%0d st=%0d",
                         $time, x, y, color, width, moved, step,
                         m_x, m_y, m_col, m_sw, m_moved, m_step);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic tap(input logic [3:0] p);
        pos = p;
        tick();
        pos = 4'd0;
        tick();
    endtask

    task automatic pulse_col(input logic [1:0] c);
        col = c;
        tick();
        col = 2'b00;
        tick();
    endtask

    task automatic pulse_sw(input logic [1:0] s);
        sw = s;
        tick();
        sw = 2'b00;
        tick();
    endtask

    int hold_c[7] = '{0, 10, 14, 18, 22, 26, 30};
    int hold_x[7] = '{5, 10, 15, 25, 35, 55, 75};

    initial begin
        int ex;
        bit em;
        int r;
        rst_n = 1'b0;
        pos   = 4'd0;
        col   = 2'b00;
        sw    = 2'b00;
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_col", int'(color), 0);
        chk("rst_w", int'(width), 0);
        chk("rst_moved", int'(moved), 0);
        chk("rst_step", int'(step), 5);

        // Single-cycle press right
        pos = 4'b0100;
        tick();
        chk("tap_x", int'(x), 5);
        chk("tap_moved", int'(moved), 1);
        chk("tap_y", int'(y), 0);
        pos = 4'd0;
        tick();
        chk("tap_moved_drop", int'(moved), 0);
        repeat (20) tick();
        chk("idle_x", int'(x), 5);
        chk("idle_moved", int'(moved), 0);

        // Hold right from x=0: repeat timing and acceleration
        do_reset();
        pos = 4'b0100;
        for (int c = 0; c <= 30; c++) begin
            tick();
            ex = 0;
            em = 1'b0;
            for (int k = 0; k < 7; k++) begin
                if (hold_c[k] <= c) ex = hold_x[k];
                if (hold_c[k] == c) em = 1'b1;
            end
            chk($sformatf("hold_x_c%0d", c), int'(x), ex);
            chk($sformatf("hold_mv_c%0d", c), int'(moved), int'(em));
            if (c == 14) chk("hold_step_c14", int'(step), 10);
            if (c == 22) chk("hold_step_c22", int'(step), 20);
            if (c == 30) chk("hold_step_c30", int'(step), 20);
        end

        // Reset mid-hold with right still pressed
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_x", int'(x), 0);
        chk("midrst_step", int'(step), 5);
        chk("midrst_moved", int'(moved), 0);
        repeat (15) tick();
        chk("midrst_held_x", int'(x), 0);
        pos = 4'd0;
        tick();
        pos = 4'b0100;
        tick();
        chk("midrst_repress_x", int'(x), 5);
        chk("midrst_repress_mv", int'(moved), 1);
        pos = 4'd0;
        tick();

        // Right-edge clamp. With a step of 5, x=635 is the nearest
        // reachable point whose next move overshoots the edge.
        do_reset();
        for (int i = 0; i < 127; i++) tap(4'b0100);
        chk("clamp_start_x", int'(x), 635);
        pos = 4'b0100;
        tick();
        chk("clamp_x", int'(x), 639);
        chk("clamp_mv", int'(moved), 1);
        pos = 4'd0;
        tick();
        pos = 4'b0100;
        tick();
        chk("clamp_again_x", int'(x), 639);
        chk("clamp_again_mv", int'(moved), 0);
        pos = 4'd0;
        tick();

        // Bottom clamp by holding, then top clamp from y=4
        pos = 4'b0010;
        repeat (150) tick();
        pos = 4'd0;
        tick();
        chk("bottom_y", int'(y), 359);
        for (int i = 0; i < 71; i++) tap(4'b0001);
        chk("up_start_y", int'(y), 4);
        pos = 4'b0001;
        tick();
        chk("top_clamp_y", int'(y), 0);
        chk("top_clamp_mv", int'(moved), 1);
        pos = 4'd0;
        tick();

        // Opposing buttons cancel
        tap(4'b0010);
        pos = 4'b0011;
        tick();
        chk("opp_y", int'(y), 5);
        chk("opp_mv", int'(moved), 0);
        pos = 4'd0;
        tick();
        pos = 4'b1100;
        tick();
        chk("opp_x", int'(x), 639);
        pos = 4'd0;
        tick();

        // Diagonal from (100,100)
        do_reset();
        for (int i = 0; i < 20; i++) tap(4'b0100);
        for (int i = 0; i < 20; i++) tap(4'b0010);
        chk("diag_start_x", int'(x), 100);
        chk("diag_start_y", int'(y), 100);
        pos = 4'b0101;
        tick();
        chk("diag_x", int'(x), 105);
        chk("diag_y", int'(y), 95);
        chk("diag_mv", int'(moved), 1);
        pos = 4'd0;
        tick();
        chk("diag_mv_drop", int'(moved), 0);

        // Colour and width wrap
        pulse_col(2'b10);
        chk("col_prev_wrap", int'(color), 15);
        pulse_col(2'b01);
        chk("col_next_wrap", int'(color), 0);
        pulse_col(2'b10);
        chk("col_prev_again", int'(color), 15);
        pulse_col(2'b11);
        chk("col_both", int'(color), 15);
        pulse_sw(2'b10);
        chk("w_narrow_wrap", int'(width), 7);
        pulse_sw(2'b01);
        chk("w_wider_wrap", int'(width), 0);
        sw = 2'b01;
        repeat (100) tick();
        sw = 2'b00;
        tick();
        chk("w_hold_once", int'(width), 1);

        // Randomised run against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 19) == 0) begin
                r = $urandom_range(0, 7);
                if (r < 2) pos = 4'd0;
                else if (r < 6) pos = 4'(1 << (r - 2));
                else pos = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 5) == 0) col = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) sw = 2'($urandom_range(0, 3));
            tick();
        end

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
